// File: rtl/key_tone_gen.sv
// key_tone_gen: keypad-driven buzzer tone generator with IDLE/TONE/GAP sequencing.
// Define NOTE_PENDING_EN to hold one key pressed during a tone or gap until the gap ends.
module key_tone_gen #(
  parameter int NOTE_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       beep,
  output logic       playing,
  output logic       busy,
  output logic [3:0] cur_note,
  output logic       pend_full
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [22:0] NOTE_LAST = 23'(NOTE_CYCLES - 1);
  localparam logic [22:0] GAP_LAST  = 23'(GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] half_cnt;
  logic [22:0] dur_cnt;
  logic [15:0] half_last;
  logic        key_stop;
  logic        key_note;
  logic        tone_done;
  logic        gap_done;
  logic        start_tone;
  logic [3:0]  start_code;
`ifdef NOTE_PENDING_EN
  logic [3:0]  pend_code;
`endif

  // Half-period of each note in clk cycles, C4 up to C6.
  function automatic logic [15:0] half_period(input logic [3:0] code);
    case (code)
      4'd0:    half_period = 16'd47778;
      4'd1:    half_period = 16'd42566;
      4'd2:    half_period = 16'd37922;
      4'd3:    half_period = 16'd35793;
      4'd4:    half_period = 16'd31888;
      4'd5:    half_period = 16'd28409;
      4'd6:    half_period = 16'd25310;
      4'd7:    half_period = 16'd23889;
      4'd8:    half_period = 16'd21283;
      4'd9:    half_period = 16'd18961;
      4'd10:   half_period = 16'd17896;
      4'd11:   half_period = 16'd15944;
      4'd12:   half_period = 16'd14205;
      4'd13:   half_period = 16'd12655;
      4'd14:   half_period = 16'd11945;
      default: half_period = 16'd1;
    endcase
  endfunction

  assign key_stop  = key_valid && (key_code == 4'd15);
  assign key_note  = key_valid && (key_code != 4'd15);
  assign tone_done = (dur_cnt == NOTE_LAST);
  assign gap_done  = (dur_cnt == GAP_LAST);
  assign half_last = half_period(cur_note) - 16'd1;

  // A fresh key wins over an expiring tone or gap in the same cycle.
  always_comb begin
    start_tone = 1'b0;
    start_code = key_code;
    case (state)
      IDLE: start_tone = key_note;
`ifdef NOTE_PENDING_EN
      GAP: begin
        if (gap_done) begin
          if (key_note) begin
            start_tone = 1'b1;
          end else if (pend_full) begin
            start_tone = 1'b1;
            start_code = pend_code;
          end
        end
      end
`else
      TONE, GAP: start_tone = key_note;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beep     <= 1'b0;
      playing  <= 1'b0;
      busy     <= 1'b0;
      cur_note <= 4'd0;
      half_cnt <= 16'd0;
      dur_cnt  <= 23'd0;
`ifdef NOTE_PENDING_EN
      pend_full <= 1'b0;
      pend_code <= 4'd0;
`endif
    end else if (key_stop) begin
      state    <= IDLE;
      beep     <= 1'b0;
      playing  <= 1'b0;
      busy     <= 1'b0;
      half_cnt <= 16'd0;
      dur_cnt  <= 23'd0;
`ifdef NOTE_PENDING_EN
      pend_full <= 1'b0;
`endif
    end else if (start_tone) begin
      state    <= TONE;
      playing  <= 1'b1;
      busy     <= 1'b1;
      beep     <= 1'b0;
      cur_note <= start_code;
      half_cnt <= 16'd0;
      dur_cnt  <= 23'd0;
`ifdef NOTE_PENDING_EN
      pend_full <= 1'b0;
`endif
    end else begin
`ifdef NOTE_PENDING_EN
      if (key_note) begin
        pend_full <= 1'b1;
        pend_code <= key_code;
      end
`endif
      case (state)
        TONE: begin
          if (tone_done) begin
            state    <= GAP;
            playing  <= 1'b0;
            beep     <= 1'b0;
            half_cnt <= 16'd0;
            dur_cnt  <= 23'd0;
          end else begin
            dur_cnt <= dur_cnt + 23'd1;
            if (half_cnt == half_last) begin
              beep     <= ~beep;
              half_cnt <= 16'd0;
            end else begin
              half_cnt <= half_cnt + 16'd1;
            end
          end
        end
        GAP: begin
          if (gap_done) begin
            state   <= IDLE;
            busy    <= 1'b0;
            dur_cnt <= 23'd0;
          end else begin
            dur_cnt <= dur_cnt + 23'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef NOTE_PENDING_EN
  assign pend_full = 1'b0;
`endif

endmodule

// File: tb/tb_key_tone_gen.sv
// tb_key_tone_gen: self-checking bench driven by a cycle-count reference model of the tone player.
// Build with NOTE_PENDING_EN defined to exercise the pending-note buffer instead of retrigger.
module tb_key_tone_gen;

  localparam int NOTE = 24000;
  localparam int GAP  = 100;
`ifdef NOTE_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       beep;
  logic       playing;
  logic       busy;
  logic [3:0] cur_note;
  logic       pend_full;
  logic [7:0] dut_vec;

  int total = 0;
  int bad   = 0;

  int half_tab[15] = '{47778, 42566, 37922, 35793, 31888, 28409, 25310, 23889,
                       21283, 18961, 17896, 15944, 14205, 12655, 11945};

  // Reference model: phase 0 idle, 1 tone, 2 gap; timing derived from edge counts.
  int         cyc = 0;
  int         m_phase = 0;
  int         m_start = 0;
  int         m_gap_start = 0;
  logic [3:0] m_note = 4'd0;
  logic [3:0] m_pcode = 4'd0;
  logic       m_pend = 1'b0;

  key_tone_gen #(
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .beep     (beep),
    .playing  (playing),
    .busy     (busy),
    .cur_note (cur_note),
    .pend_full(pend_full)
  );

  assign dut_vec = {beep, playing, busy, cur_note, pend_full};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0;
    m_note  = 4'd0;
    m_pcode = 4'd0;
    m_pend  = 1'b0;
  endtask

  task automatic model_start(input logic [3:0] kc);
    m_phase = 1;
    m_start = cyc;
    m_note  = kc;
    m_pend  = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic kv, input logic [3:0] kc);
    cyc++;
    if (r) begin
      model_reset();
      return;
    end
    if (kv && kc == 4'd15) begin
      m_phase = 0;
      m_pend  = 1'b0;
      return;
    end
    if (kv) begin
      if (!PEND || m_phase == 0) begin
        model_start(kc);
        return;
      end
      m_pend  = 1'b1;
      m_pcode = kc;
    end
    if (m_phase == 1 && cyc == m_start + NOTE) begin
      m_phase     = 2;
      m_gap_start = cyc;
    end else if (m_phase == 2 && cyc == m_gap_start + GAP) begin
      if (m_pend) model_start(m_pcode);
      else m_phase = 0;
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic b;
    b = (m_phase == 1) && ((((cyc - m_start) / half_tab[m_note]) % 2) == 1);
    return {b, (m_phase == 1), (m_phase != 0), m_note, m_pend};
  endfunction

  task automatic tick(input logic kv, input logic [3:0] kc);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(rst, kv, kc);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) tick(1'b0, 4'd0);
    total++;
    if (dut_vec !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_state: got=%b want=%b", dut_vec, 8'h00);
    end
    rst = 1'b0;
    tick(1'b0, 4'd0);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got=%b want=%b", dut_vec, model_vec());
    end
  endtask

  task automatic test_tone_gap();
    int   t0;
    int   up;
    int   dn;
    int   tog[$];
    logic pb;
    tick(1'b1, 4'd14);
    t0 = cyc;
    total++;
    if (playing !== 1'b1 || busy !== 1'b1 || beep !== 1'b0 || cur_note !== 4'd14) begin
      bad++;
      $display("[TB] FAIL tone_start: got=%b want=%b", dut_vec, 8'b0111_1100);
    end
    pb = beep;
    up = -1;
    dn = -1;
    for (int i = 0; i < NOTE + GAP + 5; i++) begin
      tick(1'b0, 4'd0);
      if (bad < 40) begin
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("[TB] FAIL tone_gap_track: got=%b want=%b cyc=%0d", dut_vec, model_vec(), cyc);
        end
      end
      if (beep !== pb) tog.push_back(cyc - t0);
      pb = beep;
      if (up < 0 && playing !== 1'b1) up = cyc - t0;
      if (dn < 0 && busy !== 1'b1) dn = cyc - t0;
    end
    total++;
    if (tog.size() != 2) begin
      bad++;
      $display("[TB] FAIL toggle_count: got=%0d want=2", tog.size());
    end else if (tog[0] != 11945 || tog[1] != 23890) begin
      bad++;
      $display("[TB] FAIL toggle_times: got=%0d,%0d want=11945,23890", tog[0], tog[1]);
    end
    total++;
    if (up != NOTE) begin
      bad++;
      $display("[TB] FAIL playing_fall: got=%0d want=%0d", up, NOTE);
    end
    total++;
    if (dn != NOTE + GAP) begin
      bad++;
      $display("[TB] FAIL busy_fall: got=%0d want=%0d", dn, NOTE + GAP);
    end
  endtask

  task automatic test_stop();
    tick(1'b1, 4'd0);
    repeat (999) tick(1'b0, 4'd0);
    total++;
    if (playing !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stop_pre: got=%b want=playing,busy high", dut_vec);
    end
    tick(1'b1, 4'd15);
    total++;
    if (dut_vec !== 8'h00) begin
      bad++;
      $display("[TB] FAIL stop_immediate: got=%b want=%b", dut_vec, 8'h00);
    end
    tick(1'b0, 4'd0);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("[TB] FAIL stop_hold: got=%b want=%b", dut_vec, model_vec());
    end
  endtask

`ifndef NOTE_PENDING_EN
  task automatic test_retrigger();
    int t1;
    int first;
    tick(1'b1, 4'd3);
    for (int i = 0; i < 5999; i++) begin
      tick(1'b0, 4'd0);
      if (bad < 40) begin
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("[TB] FAIL retrig_track: got=%b want=%b cyc=%0d", dut_vec, model_vec(), cyc);
        end
      end
    end
    tick(1'b1, 4'd9);
    t1 = cyc;
    total++;
    if (cur_note !== 4'd9 || beep !== 1'b0 || playing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL retrigger_load: got=%b want=%b", dut_vec, 8'b0111_0010);
    end
    first = -1;
    for (int i = 0; i < NOTE - 1; i++) begin
      tick(1'b0, 4'd0);
      if (bad < 40) begin
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("[TB] FAIL retrig_tone_track: got=%b want=%b cyc=%0d", dut_vec, model_vec(), cyc);
        end
      end
      if (first < 0 && beep === 1'b1) first = cyc - t1;
    end
    total++;
    if (first != 18961) begin
      bad++;
      $display("[TB] FAIL retrigger_first_toggle: got=%0d want=18961", first);
    end
    total++;
    if (playing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_note_restart: got playing=%b want=1", playing);
    end
    tick(1'b1, 4'd5);
    total++;
    if (playing !== 1'b1 || busy !== 1'b1 || cur_note !== 4'd5 || beep !== 1'b0) begin
      bad++;
      $display("[TB] FAIL key_at_expiry: got=%b want=%b", dut_vec, 8'b0110_1010);
    end
    tick(1'b1, 4'd15);
  endtask
`else
  task automatic test_pending();
    int t0;
    tick(1'b1, 4'd3);
    t0 = cyc;
    repeat (5999) tick(1'b0, 4'd0);
    tick(1'b1, 4'd7);
    total++;
    if (pend_full !== 1'b1 || cur_note !== 4'd3 || playing !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pend_store: got=%b want=%b", dut_vec, 8'b0110_0111);
    end
    repeat (3999) tick(1'b0, 4'd0);
    tick(1'b1, 4'd8);
    while (cyc < t0 + NOTE) begin
      tick(1'b0, 4'd0);
      if (bad < 40) begin
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("[TB] FAIL pend_track: got=%b want=%b cyc=%0d", dut_vec, model_vec(), cyc);
        end
      end
    end
    total++;
    if (playing !== 1'b0 || busy !== 1'b1 || pend_full !== 1'b1 || cur_note !== 4'd3) begin
      bad++;
      $display("[TB] FAIL pend_note_done: got=%b want=%b", dut_vec, 8'b0010_0111);
    end
    while (cyc < t0 + NOTE + GAP) tick(1'b0, 4'd0);
    total++;
    if (playing !== 1'b1 || cur_note !== 4'd8 || pend_full !== 1'b0 || beep !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pend_play: got=%b want=%b", dut_vec, 8'b0111_0000);
    end
    repeat (50) tick(1'b0, 4'd0);
    tick(1'b1, 4'd15);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("[TB] FAIL pend_stop: got=%b want=%b", dut_vec, model_vec());
    end
  endtask
`endif

  task automatic test_reset_mid();
    tick(1'b1, 4'd14);
    repeat (12000) tick(1'b0, 4'd0);
    total++;
    if (beep !== 1'b1) begin
      bad++;
      $display("[TB] FAIL beep_before_reset: got=%b want=1", beep);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_vec !== 8'h00) begin
      bad++;
      $display("[TB] FAIL async_reset: got=%b want=%b", dut_vec, 8'h00);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'd0);
      total++;
      if (dut_vec !== 8'h00) begin
        bad++;
        $display("[TB] FAIL reset_hold: got=%b want=%b", dut_vec, 8'h00);
      end
    end
    rst = 1'b0;
    tick(1'b0, 4'd0);
    tick(1'b1, 4'd4);
    total++;
    if (playing !== 1'b1 || cur_note !== 4'd4 || beep !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_key_after_reset: got=%b want=%b", dut_vec, 8'b0110_1000);
    end
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 4'd0);
      if (bad < 40) begin
        total++;
        if (dut_vec !== model_vec()) begin
          bad++;
          $display("[TB] FAIL post_reset_track: got=%b want=%b cyc=%0d", dut_vec, model_vec(), cyc);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] kc;
    int         n;
    for (int k = 0; k < 10; k++) begin
      kc = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      tick(1'b1, kc);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        $display("[TB] FAIL random_key: got=%b want=%b key=%0d", dut_vec, model_vec(), kc);
      end
      n = $urandom_range(1, 800);
      for (int i = 0; i < n; i++) begin
        tick(1'b0, 4'd0);
        if (bad < 40) begin
          total++;
          if (dut_vec !== model_vec()) begin
            bad++;
            $display("[TB] FAIL random_track: got=%b want=%b cyc=%0d", dut_vec, model_vec(), cyc);
          end
        end
      end
    end
    tick(1'b1, 4'd15);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("[TB] FAIL random_stop: got=%b want=%b", dut_vec, model_vec());
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    $display("[TB] starting key_tone_gen bench");
    test_reset();
    test_tone_gap();
    test_stop();
`ifdef NOTE_PENDING_EN
    test_pending();
`else
    test_retrigger();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
